div: RTL
========

DIV -- requirements
Module: div

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset: rst, synchronous, active-high.
REQ-003 signed_div_i  input  1  1 = signed (two's complement) divide, 0 = unsigned.
REQ-004 opdata1_i  input  32  dividend, sampled only on accepted start.
REQ-005 opdata2_i  input  32  divisor, sampled only on accepted start.
REQ-006 start_i  input  1  1 = request divide, held high by EX until ready_o seen.
REQ-007 annul_i  input  1  1 = abort an in-progress divide.
REQ-008 result_o  output  64  [63:32] remainder (to HI), [31:0] quotient (to LO).
REQ-009 ready_o  output  1  1 = result_o valid.

Function
REQ-010 FSM states: FREE, BYZERO, ON, END; 6-bit iteration counter cnt; 65-bit working register dividend; 32-bit captured divisor.
REQ-011 FREE: start_i=1 and annul_i=0 -> capture operands; divisor==0 -> BYZERO, else -> ON, cnt=0.
REQ-012 FREE: start_i=0 or annul_i=1 -> stay FREE; ready_o=0, result_o=0.
REQ-013 Signed mode capture: store absolute values of operands; 0x80000000 kept as 0x80000000 unsigned.
REQ-014 Unsigned mode capture: operands stored unchanged.
REQ-015 Capture: dividend = {32'b0, |op1|, 1'b0}.
REQ-016 ON, annul_i=0, cnt<32: one restoring step per cycle, cnt+1; trial = dividend[64:32] - {1'b0, divisor}.
REQ-017 Step, trial negative: dividend = dividend << 1.
REQ-018 Step, trial non-negative: dividend = {trial[31:0], dividend[31:0], 1'b1}.
REQ-019 ON, cnt==32: apply sign fix-up, -> END.
REQ-020 Fix-up quotient (dividend[31:0]): negated if signed and op1[31]^op2[31].
REQ-021 Fix-up remainder (dividend[64:33]): negated if signed and op1[31]=1.
REQ-022 ON, annul_i=1 (any cnt): -> FREE next edge; ready_o stays 0, result_o=0.
REQ-023 BYZERO: -> END next edge with result 0.
REQ-024 END: ready_o=1, result_o = final {remainder, quotient}.
REQ-025 END: held while start_i=1; start_i=0 -> FREE, ready_o=0, result_o=0 next edge.
REQ-026 Latency: start accepted at edge N -> ready_o=1 after edge N+33 (normal), N+2 (divide-by-zero).
REQ-027 start_i ignored and operand changes ignored in ON, BYZERO, END.
REQ-028 annul_i ignored in BYZERO and END.
REQ-029 Signed 0x80000000 / 0xFFFFFFFF: quotient wraps to 0x80000000, remainder 0; no exception.
REQ-030 ready_o and result_o are registered; no combinational input-to-output path.

Reset
REQ-031 rst=1 at a clock edge: state=FREE, cnt=0, dividend=0, divisor=0, result_o=0, ready_o=0.
REQ-032 rst overrides all inputs in every state, including mid-ON; no partial result ever appears.

Verification
REQ-033 Unsigned 100/7: ready_o after edge N+33; result_o=0x00000002_0000000E.
REQ-034 Signed -7/2 (0xFFFFFFF9, 0x00000002): result_o=0xFFFFFFFF_FFFFFFFD.
REQ-035 Signed 7/-2: result_o=0x00000001_FFFFFFFD.
REQ-036 Unsigned 0xFFFFFFFF/1: result_o=0x00000000_FFFFFFFF.
REQ-037 Any/0: ready_o after edge N+2, result_o=0.
REQ-038 Drop start_i after ready_o: ready_o=0 next edge.
REQ-039 annul_i=1 at cnt=10: FREE next edge, ready_o never asserted; following start 9/3 -> 0x00000000_00000003.
REQ-040 rst=1 at cnt=20: all outputs 0 next edge; fresh start 0x80000000/0xFFFFFFFF signed -> 0x00000000_80000000.

Source files
------------

// File: rtl/div.sv
// Iterative 32-bit restoring divider, one quotient bit per cycle, signed or unsigned.
// Produces {remainder, quotient}; divide-by-zero returns zero after a short path.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      r_state, r_state_next;
  logic [5:0]  r_cnt, r_cnt_next;
  logic [64:0] r_dividend, r_dividend_next;
  logic [31:0] r_divisor, r_divisor_next;
  logic        r_neg_q, r_neg_q_next;
  logic        r_neg_r, r_neg_r_next;
  logic        r_ready, r_ready_next;
  logic [63:0] r_result, r_result_next;

  logic [31:0] w_abs1, w_abs2;
  logic [32:0] w_trial;
  logic [31:0] w_quo, w_rem;

  // 0x80000000 negates to itself, which is exactly its unsigned magnitude.
  assign w_abs1 = (signed_div_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
  assign w_abs2 = (signed_div_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;

  assign w_trial = r_dividend[64:32] - {1'b0, r_divisor};
  assign w_quo   = r_neg_q ? (32'd0 - r_dividend[31:0])  : r_dividend[31:0];
  assign w_rem   = r_neg_r ? (32'd0 - r_dividend[64:33]) : r_dividend[64:33];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= FREE;
      r_cnt      <= 6'd0;
      r_dividend <= 65'd0;
      r_divisor  <= 32'd0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_ready    <= 1'b0;
      r_result   <= 64'd0;
    end else begin
      r_state    <= r_state_next;
      r_cnt      <= r_cnt_next;
      r_dividend <= r_dividend_next;
      r_divisor  <= r_divisor_next;
      r_neg_q    <= r_neg_q_next;
      r_neg_r    <= r_neg_r_next;
      r_ready    <= r_ready_next;
      r_result   <= r_result_next;
    end
  end

  always_comb begin
    r_state_next    = r_state;
    r_cnt_next      = r_cnt;
    r_dividend_next = r_dividend;
    r_divisor_next  = r_divisor;
    r_neg_q_next    = r_neg_q;
    r_neg_r_next    = r_neg_r;
    r_ready_next    = 1'b0;
    r_result_next   = 64'd0;

    case (r_state)
      FREE: begin
        if (start_i && !annul_i) begin
          r_divisor_next  = w_abs2;
          r_dividend_next = {32'd0, w_abs1, 1'b0};
          r_neg_q_next    = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
          r_neg_r_next    = signed_div_i && opdata1_i[31];
          r_cnt_next      = 6'd0;
          r_state_next    = (opdata2_i == 32'd0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        r_dividend_next = 65'd0;
        r_state_next    = END;
      end
      ON: begin
        if (annul_i) begin
          r_state_next = FREE;
          r_cnt_next   = 6'd0;
        end else if (r_cnt != 6'd32) begin
          r_cnt_next = r_cnt + 6'd1;
          if (w_trial[32])
            r_dividend_next = {r_dividend[63:0], 1'b0};
          else
            r_dividend_next = {w_trial[31:0], r_dividend[31:0], 1'b1};
        end else begin
          // Fix-up is stored back so END can keep re-presenting the same result.
          r_dividend_next = {w_rem, r_dividend[32], w_quo};
          r_state_next    = END;
          r_ready_next    = 1'b1;
          r_result_next   = {w_rem, w_quo};
        end
      end
      END: begin
        if (start_i) begin
          r_ready_next  = 1'b1;
          r_result_next = {r_dividend[64:33], r_dividend[31:0]};
        end else begin
          r_state_next = FREE;
        end
      end
      default: r_state_next = FREE;
    endcase
  end

  assign ready_o  = r_ready;
  assign result_o = r_result;

endmodule
